// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and derived totals for
// the pixel-pipeline blocks.
package vga_pkg;

   localparam int unsigned HActiveDef = 640;
   localparam int unsigned HFpDef     = 16;
   localparam int unsigned HSyncDef   = 96;
   localparam int unsigned HBpDef     = 48;

   localparam int unsigned VActiveDef = 480;
   localparam int unsigned VFpDef     = 10;
   localparam int unsigned VSyncDef   = 2;
   localparam int unsigned VBpDef     = 33;

   localparam int unsigned ClkDivDef  = 4;
   localparam int unsigned CwDef      = 10;

   // Length of one axis: sync, back porch, active, front porch.
   function automatic int unsigned axis_total(int unsigned sync, int unsigned bp,
                                              int unsigned active, int unsigned fp);
      return sync + bp + active + fp;
   endfunction

   localparam int unsigned HTotalDef = axis_total(HSyncDef, HBpDef, HActiveDef, HFpDef);
   localparam int unsigned VTotalDef = axis_total(VSyncDef, VBpDef, VActiveDef, VFpDef);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to the pixel pipeline / pins.
interface vga_timing_gen_if #(
   parameter int unsigned CW = 10
);
   logic          pix_stb;
   logic          hSync;
   logic          vSync;
   logic          bright;
   logic [CW-1:0] hCount;
   logic [CW-1:0] vCount;
   logic [CW-1:0] x;
   logic [CW-1:0] y;
   logic          line_start;
   logic          frame_start;

   modport master (
      output pix_stb, hSync, vSync, bright, hCount, vCount, x, y, line_start, frame_start
   );

   modport slave (
      input pix_stb, hSync, vSync, bright, hCount, vCount, x, y, line_start, frame_start
   );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with registered sync. The active flag and
// coordinate are derived from the next-state count so the parent can register
// them in the same edge that moves the count.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int unsigned SYNC   = HSyncDef,
   parameter int unsigned BP     = HBpDef,
   parameter int unsigned ACTIVE = HActiveDef,
   parameter int unsigned FP     = HFpDef,
   parameter bit          POL    = 1'b0,
   parameter int unsigned CW     = CwDef
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          advance,
   output logic [CW-1:0] count,
   output logic          wrap,
   output logic          sync,
   output logic          active,
   output logic [CW-1:0] coord
);

   localparam int unsigned Total = axis_total(SYNC, BP, ACTIVE, FP);
   localparam int unsigned Start = SYNC + BP;
   localparam int unsigned Stop  = Start + ACTIVE;

   logic [CW-1:0] count_q, count_d;
   logic          sync_q, sync_d;

   assign wrap = (count_q == CW'(Total - 1));

   // Next count, sync level and active-window decode of the next count.
   always_comb begin
      count_d = count_q;
      if (advance) begin
         count_d = wrap ? '0 : count_q + CW'(1);
      end
      // Compare at 32 bits so Stop == 2^CW cannot overflow.
      sync_d = (32'(count_d) < SYNC) ? POL : ~POL;
      active = (32'(count_d) >= Start) && (32'(count_d) < Stop);
      coord  = active ? count_d - CW'(Start) : '0;
   end

   // Position and sync registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         sync_q  <= POL;
      end else begin
         count_q <= count_d;
         sync_q  <= sync_d;
      end
   end

   assign count = count_q;
   assign sync  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-strobe divider, horizontal
// and vertical axis counters, and registered blanking/coordinate/marker outputs.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = HActiveDef,
   parameter int unsigned H_FP     = HFpDef,
   parameter int unsigned H_SYNC   = HSyncDef,
   parameter int unsigned H_BP     = HBpDef,
   parameter int unsigned V_ACTIVE = VActiveDef,
   parameter int unsigned V_FP     = VFpDef,
   parameter int unsigned V_SYNC   = VSyncDef,
   parameter int unsigned V_BP     = VBpDef,
   parameter bit          H_POL    = 1'b0,
   parameter bit          V_POL    = 1'b0,
   parameter int unsigned CLK_DIV  = ClkDivDef,
   parameter int unsigned CW       = CwDef
) (
   input  logic             clk,
   input  logic             rst,
   vga_timing_gen_if.master vga
);

   localparam int unsigned HTotal = axis_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
   localparam int unsigned VTotal = axis_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
   localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   if (64'(HTotal) > (64'd1 << CW)) begin : g_bad_htotal
      $error("H_TOTAL does not fit in CW bits");
   end
   if (64'(VTotal) > (64'd1 << CW)) begin : g_bad_vtotal
      $error("V_TOTAL does not fit in CW bits");
   end
   if (CLK_DIV < 1) begin : g_bad_div
      $error("CLK_DIV must be at least 1");
   end

   logic [DivW-1:0] div_q, div_d;
   logic            tick;
   logic            h_wrap, v_wrap, v_adv;
   logic            h_active, v_active;
   logic [CW-1:0]   h_coord, v_coord;
   logic [CW-1:0]   h_count, v_count;
   logic            h_sync, v_sync;

   logic            bright_d, bright_q;
   logic [CW-1:0]   x_d, x_q, y_d, y_q;
   logic            line_d, line_q, frame_d, frame_q, pix_stb_q;

   // With CLK_DIV == 1 the divider stays at 0, which is also its last value.
   assign tick  = (div_q == DivW'(CLK_DIV - 1));
   assign div_d = tick ? '0 : div_q + DivW'(1);
   assign v_adv = tick & h_wrap;

   vga_axis_counter #(
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .POL    (H_POL),
      .CW     (CW)
   ) u_h (
      .clk     (clk),
      .rst     (rst),
      .advance (tick),
      .count   (h_count),
      .wrap    (h_wrap),
      .sync    (h_sync),
      .active  (h_active),
      .coord   (h_coord)
   );

   vga_axis_counter #(
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .POL    (V_POL),
      .CW     (CW)
   ) u_v (
      .clk     (clk),
      .rst     (rst),
      .advance (v_adv),
      .count   (v_count),
      .wrap    (v_wrap),
      .sync    (v_sync),
      .active  (v_active),
      .coord   (v_coord)
   );

   // Blanking, gated coordinates and wrap markers for the upcoming pixel.
   always_comb begin
      bright_d = h_active & v_active;
      x_d      = bright_d ? h_coord : '0;
      y_d      = bright_d ? v_coord : '0;
      line_d   = tick & h_wrap;
      frame_d  = tick & h_wrap & v_wrap;
   end

   // Divider and output registers; strobe/markers last one clk after the tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q     <= '0;
         pix_stb_q <= 1'b0;
         bright_q  <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
         line_q    <= 1'b0;
         frame_q   <= 1'b0;
      end else begin
         div_q     <= div_d;
         pix_stb_q <= tick;
         bright_q  <= bright_d;
         x_q       <= x_d;
         y_q       <= y_d;
         line_q    <= line_d;
         frame_q   <= frame_d;
      end
   end

   assign vga.pix_stb     = pix_stb_q;
   assign vga.hSync       = h_sync;
   assign vga.vSync       = v_sync;
   assign vga.bright      = bright_q;
   assign vga.hCount      = h_count;
   assign vga.vCount      = v_count;
   assign vga.x           = x_q;
   assign vga.y           = y_q;
   assign vga.line_start  = line_q;
   assign vga.frame_start = frame_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator replacing the fixed 640x480 controller. It derives a pixel strobe from the system clock and runs horizontal and vertical counters with fully parametrised porch, sync and active lengths. It drives registered sync, blanking, raw counts, active-area coordinates and frame/line markers to the pixel pipeline and the VGA pins. All outputs describe the same pixel in the same cycle.

## Interface

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- H_POL, 0, hSync asserted level (0 = active-low)
- V_POL, 0, vSync asserted level
- CLK_DIV, 4, clk cycles per pixel (>= 1)
- CW, 10, counter/coordinate width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- pix_stb  out  1  high in the first clk cycle of each pixel
- hSync  out  1  horizontal sync, polarity H_POL
- vSync  out  1  vertical sync, polarity V_POL
- bright  out  1  pixel is inside the active area
- hCount  out  CW  raw horizontal position, 0..H_TOTAL-1
- vCount  out  CW  raw vertical position, 0..V_TOTAL-1
- x  out  CW  active-area column, 0..H_ACTIVE-1; 0 when bright=0
- y  out  CW  active-area row, 0..V_ACTIVE-1; 0 when bright=0
- line_start  out  1  one-clk pulse at entry to hCount=0
- frame_start  out  1  one-clk pulse at entry to (hCount,vCount)=(0,0)

## Operation

- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (800); V_TOTAL likewise (525). Per-axis line order: sync, back porch, active, front porch.
- Divider div_cnt runs 0..CLK_DIV-1 and wraps. An internal tick fires when div_cnt = CLK_DIV-1. With CLK_DIV=1, tick is constant 1.
- On tick, hCount increments. At H_TOTAL-1 it wraps to 0 and vCount increments. vCount wraps from V_TOTAL-1 to 0.
- hSync is at its asserted level iff hCount < H_SYNC. vSync is at its asserted level iff vCount < V_SYNC.
- bright = 1 iff H_SYNC+H_BP <= hCount < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP <= vCount < V_SYNC+V_BP+V_ACTIVE. Bounds are inclusive/exclusive exactly as written.
- x = hCount-(H_SYNC+H_BP) and y = vCount-(V_SYNC+V_BP) when bright=1, otherwise 0.
- All outputs are registered. They are computed from the next-state counts so that they change in the same edge as hCount/vCount.
- Arithmetic is unsigned, CW bits. Elaboration fails if H_TOTAL > 2^CW, V_TOTAL > 2^CW or CLK_DIV < 1.

## Timing

- Reset (async assert, sync release): div_cnt=0, hCount=vCount=0, x=y=0, bright=0, hSync=H_POL, vSync=V_POL, pix_stb=0, line_start=0, frame_start=0.
- First tick after reset release occurs CLK_DIV clk edges later and moves to hCount=1. Pixel (0,0) after reset gets no frame_start or line_start.
- pix_stb, line_start and frame_start are high only in the clk cycle immediately following the tick edge. They are low for the remaining CLK_DIV-1 cycles. With CLK_DIV=1, pix_stb stays at 1 and the markers are 1 for exactly one clk.
- A line is H_TOTAL*CLK_DIV clk cycles long (3200). A frame is V_TOTAL lines long (1,680,000 clk at defaults).
- Simultaneous wraps: at (H_TOTAL-1, V_TOTAL-1), one tick sets both counts to 0 and asserts both line_start and frame_start.
- Reset mid-frame forces the reset state immediately, independent of clk. The next frame restarts from (0,0).

## Structure

- Shared package vga_pkg holds the default timing constants for 640x480@60 and the derived H_TOTAL/V_TOTAL expressions, for use by the pixel-pipeline blocks.
- One sub-module, vga_axis_counter, is instantiated twice: horizontal with advance=tick, vertical with advance=tick & h_wrap. It is parameters (SYNC, BP, ACTIVE, FP, POL, CW) with ports clk, rst, advance, count, wrap, sync, active, coord.
- The top level contains the divider, the AND of the two active terms and the marker registers.

## Test plan

- Reset: hold rst, then release. All outputs hold their reset values. The first pix_stb appears 4 clk after release with hCount=1.
- Defaults, one full frame: hSync low exactly 96 px/line. vSync low for lines 0-1. bright is high for 640x480 px, first at (144,35) with x=y=0, last at (783,514) with x=639, y=479.
- Wrap: at (799,524) the next tick gives (0,0) with line_start=1 and frame_start=1 for one clk. At (799,10) the next tick gives (0,11) with line_start only.
- CLK_DIV=1, H_POL=V_POL=1: pix_stb is constant 1, syncs are active-high, and a line lasts 800 clk.
- Small custom timing (H 8/1/2/1, V 4/1/1/1, CW=4): frame is 12x7 px. bright count is 32 per frame and x/y sequences match.
- Assert rst at (400,200) mid-pixel: outputs reset without a clk edge. After release the counts restart from 0 and the next frame timing is nominal.
